// File: rtl/pc_pkg.sv
// Shared definitions for the PC sequencer slice.
//   - pcsrc encodings reported on o_pcsrc
//   - default reset / exception vectors (32-bit, resized by the users)
//   - instruction immediate field widths
package pc_pkg;

  localparam int IMM26_W = 26;
  localparam int IMM16_W = 16;

  localparam logic [1:0] PCSRC_SEQ  = 2'b00;  // pc + 4
  localparam logic [1:0] PCSRC_BR   = 2'b01;  // taken branch, jump or jr
  localparam logic [1:0] PCSRC_ERET = 2'b10;  // return to epc
  localparam logic [1:0] PCSRC_EXC  = 2'b11;  // exception vector

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0180;

endpackage

// File: rtl/pc_trace_buf.sv
// Circular trace buffer of redirect source PCs.
//   clk, rst  : clock, synchronous active-high reset (clears pointer and count)
//   wr_en     : push wr_data as the newest entry
//   wr_data   : PC value to record
//   rd_idx    : read index, 0 = newest entry
//   rd_data   : entry at rd_idx, 0 when rd_idx >= count (combinational)
//   count     : number of valid entries, saturates at DEPTH
// Reads come straight from the registers, so a read in the same cycle as a
// write sees the contents from before that write.
module pc_trace_buf #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_data,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic [ADDR_W-1:0]          rd_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  wr_ptr;
  logic [IDX_W:0]    count_q;
  logic [IDX_W-1:0]  rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + IDX_W'(1);
      if (count_q != (IDX_W+1)'(DEPTH))
        count_q <= count_q + (IDX_W+1)'(1);
    end
  end

  // Storage needs no reset: entries beyond count_q are never exposed.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= wr_data;
  end

  // Newest entry sits just below the write pointer; DEPTH is a power of
  // two so the subtraction wraps around the ring for free.
  assign rd_ptr = wr_ptr - IDX_W'(1) - rd_idx;

  always_comb begin
    rd_data = '0;
    if ({1'b0, rd_idx} < count_q)
      rd_data = mem[rd_ptr];
  end

  assign count = count_q;

endmodule

// File: rtl/pc_sequencer.sv
// Architectural PC register and next-PC selection for the unpipelined core.
// Optional feature macro: PC_TRACE_EN (redirect trace buffer).
// Ports:
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_stall        : hold PC (eret/exception still update)
//   i_imm          : 26-bit immediate (branch offset uses [15:0])
//   i_jump, i_jr   : J/JAL, JR/JALR
//   i_beq, i_bne   : branch decodes, i_zerof is the ALU zero flag
//   i_Rs           : jump-register target
//   i_eret         : exception return, i_exception : exception request
//   o_pc           : current PC (registered), o_pc_plus4 : o_pc + 4
//   o_epc          : exception PC, o_pcsrc : selected source this cycle
//   o_addr_err     : misaligned JR target this cycle
//   i_trace_idx, o_trace_pc, o_trace_cnt : trace read port (PC_TRACE_EN)
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEF_RESET_VECTOR),
  parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(DEF_EXC_VECTOR),
  parameter int                TRACE_DEPTH  = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_stall,
  input  logic [IMM26_W-1:0]             i_imm,
  input  logic                           i_jump,
  input  logic                           i_beq,
  input  logic                           i_bne,
  input  logic                           i_zerof,
  input  logic                           i_jr,
  input  logic [ADDR_W-1:0]              i_Rs,
  input  logic                           i_eret,
  input  logic                           i_exception,
  output logic [ADDR_W-1:0]              o_pc,
  output logic [ADDR_W-1:0]              o_pc_plus4,
  output logic [ADDR_W-1:0]              o_epc,
  output logic [1:0]                     o_pcsrc,
  output logic                           o_addr_err,
  input  logic [$clog2(TRACE_DEPTH)-1:0] i_trace_idx,
  output logic [ADDR_W-1:0]              o_trace_pc,
  output logic [$clog2(TRACE_DEPTH):0]   o_trace_cnt
);

  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  epc_q;
  logic [ADDR_W-1:0]  pc_plus4;
  logic [ADDR_W-1:0]  br_off;
  logic [ADDR_W-1:0]  br_tgt;
  logic [ADDR_W-1:0]  jmp_tgt;
  logic [ADDR_W-1:0]  next_pc;
  logic [IMM16_W-1:0] imm16;
  logic [1:0]         pcsrc;
  logic               br_taken;
  logic               exc_take;
  logic               pc_upd;

  assign imm16    = i_imm[IMM16_W-1:0];
  assign pc_plus4 = pc_q + ADDR_W'(4);
  assign br_off   = {{(ADDR_W-IMM16_W-2){imm16[IMM16_W-1]}}, imm16, 2'b00};
  assign br_tgt   = pc_plus4 + br_off;
  assign jmp_tgt  = {pc_plus4[ADDR_W-1:28], i_imm, 2'b00};
  assign br_taken = (i_beq & i_zerof) | (i_bne & ~i_zerof);

  // A misaligned JR is turned into an exception, unless a higher-priority
  // eret or a real exception is already redirecting this cycle.
  assign o_addr_err = i_jr & (|i_Rs[1:0]) & ~i_eret & ~i_exception;

  // Eret outranks exception, so an exception alongside eret is dropped.
  assign exc_take = ~i_eret & (i_exception | o_addr_err);

  always_comb begin
    pcsrc   = PCSRC_SEQ;
    next_pc = pc_plus4;
    if (i_eret) begin
      pcsrc   = PCSRC_ERET;
      next_pc = epc_q;
    end else if (exc_take) begin
      pcsrc   = PCSRC_EXC;
      next_pc = EXC_VECTOR;
    end else if (i_jr) begin
      pcsrc   = PCSRC_BR;
      next_pc = i_Rs;
    end else if (i_jump) begin
      pcsrc   = PCSRC_BR;
      next_pc = jmp_tgt;
    end else if (br_taken) begin
      pcsrc   = PCSRC_BR;
      next_pc = br_tgt;
    end
  end

  // Stall only freezes the ordinary flow; eret/exception break through it.
  assign pc_upd = ~i_stall | i_eret | exc_take;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q  <= RESET_VECTOR;
      epc_q <= '0;
    end else begin
      if (pc_upd)
        pc_q <= next_pc;
      if (exc_take)
        epc_q <= pc_q;
    end
  end

  assign o_pc       = pc_q;
  assign o_pc_plus4 = pc_plus4;
  assign o_epc      = epc_q;
  assign o_pcsrc    = pcsrc;

`ifdef PC_TRACE_EN
  logic trace_we;

  // Record the PC being left on every redirect that actually happens.
  assign trace_we = ~i_rst & pc_upd & (pcsrc != PCSRC_SEQ);

  pc_trace_buf #(
    .ADDR_W (ADDR_W),
    .DEPTH  (TRACE_DEPTH)
  ) u_trace (
    .clk     (i_clk),
    .rst     (i_rst),
    .wr_en   (trace_we),
    .wr_data (pc_q),
    .rd_idx  (i_trace_idx),
    .rd_data (o_trace_pc),
    .count   (o_trace_cnt)
  );
`else
  logic unused_trace_idx;

  assign unused_trace_idx = ^i_trace_idx;
  assign o_trace_pc       = '0;
  assign o_trace_cnt      = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (default parameters, ADDR_W=32, depth 8).
module tb_pc_sequencer;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_stall = 1'b0;
  logic [25:0] i_imm = '0;
  logic        i_jump = 1'b0;
  logic        i_beq = 1'b0;
  logic        i_bne = 1'b0;
  logic        i_zerof = 1'b0;
  logic        i_jr = 1'b0;
  logic [31:0] i_Rs = '0;
  logic        i_eret = 1'b0;
  logic        i_exception = 1'b0;
  logic [2:0]  i_trace_idx = '0;
  logic [31:0] o_pc, o_pc_plus4, o_epc, o_trace_pc;
  logic [1:0]  o_pcsrc;
  logic        o_addr_err;
  logic [3:0]  o_trace_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;

  pc_sequencer dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_stall(i_stall), .i_imm(i_imm),
    .i_jump(i_jump), .i_beq(i_beq), .i_bne(i_bne), .i_zerof(i_zerof),
    .i_jr(i_jr), .i_Rs(i_Rs), .i_eret(i_eret), .i_exception(i_exception),
    .o_pc(o_pc), .o_pc_plus4(o_pc_plus4), .o_epc(o_epc), .o_pcsrc(o_pcsrc),
    .o_addr_err(o_addr_err), .i_trace_idx(i_trace_idx),
    .o_trace_pc(o_trace_pc), .o_trace_cnt(o_trace_cnt)
  );

  // Clock / step
  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Driver tasks
  task automatic clear_inputs();
    i_stall = 0; i_imm = '0; i_jump = 0; i_beq = 0; i_bne = 0; i_zerof = 0;
    i_jr = 0; i_Rs = '0; i_eret = 0; i_exception = 0; i_trace_idx = '0;
  endtask

  // Aligned JR places the PC anywhere in one cycle.
  task automatic set_pc(input logic [31:0] v);
    i_jr = 1; i_Rs = v;
    step();
    i_jr = 0; i_Rs = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    i_rst = 1;
    step(); step();
    i_rst = 0;
    total_cnt++;
    if (o_pc !== 32'h0) $display("FAIL reset_pc: got %h want %h", o_pc, 32'h0);
    else pass_cnt++;
    total_cnt++;
    if (o_epc !== 32'h0) $display("FAIL reset_epc: got %h want %h", o_epc, 32'h0);
    else pass_cnt++;
    total_cnt++;
    if (o_trace_cnt !== 4'd0) $display("FAIL reset_trace_cnt: got %0d want 0", o_trace_cnt);
    else pass_cnt++;
    for (int k = 1; k <= 3; k++) begin
      step();
      total_cnt++;
      if (o_pc !== 32'(4 * k)) $display("FAIL seq_pc%0d: got %h want %h", k, o_pc, 32'(4 * k));
      else pass_cnt++;
      total_cnt++;
      if (o_pcsrc !== 2'b00) $display("FAIL seq_pcsrc%0d: got %b want 00", k, o_pcsrc);
      else pass_cnt++;
    end
    total_cnt++;
    if (o_pc_plus4 !== 32'h10) $display("FAIL pc_plus4: got %h want %h", o_pc_plus4, 32'h10);
    else pass_cnt++;
    total_cnt++;
    if (o_epc !== 32'h0) $display("FAIL seq_epc: got %h want %h", o_epc, 32'h0);
    else pass_cnt++;
  endtask

  task automatic test_branch();
    clear_inputs();
    set_pc(32'h100);
    i_beq = 1; i_zerof = 1; i_imm = 26'h000FFFE;
    #1;
    total_cnt++;
    if (o_pcsrc !== 2'b01) $display("FAIL beq_taken_pcsrc: got %b want 01", o_pcsrc);
    else pass_cnt++;
    step();
    total_cnt++;
    if (o_pc !== 32'h0FC) $display("FAIL beq_taken_pc: got %h want %h", o_pc, 32'h0FC);
    else pass_cnt++;
    clear_inputs();
    set_pc(32'h100);
    i_beq = 1; i_zerof = 0; i_imm = 26'h000FFFE;
    #1;
    total_cnt++;
    if (o_pcsrc !== 2'b00) $display("FAIL beq_nt_pcsrc: got %b want 00", o_pcsrc);
    else pass_cnt++;
    step();
    total_cnt++;
    if (o_pc !== 32'h104) $display("FAIL beq_nt_pc: got %h want %h", o_pc, 32'h104);
    else pass_cnt++;
    // BNE with zero flag clear, forward offset 3 words: 0x108 + 0xC
    i_beq = 0; i_bne = 1; i_zerof = 0; i_imm = 26'h0000003;
    step();
    total_cnt++;
    if (o_pc !== 32'h114) $display("FAIL bne_taken_pc: got %h want %h", o_pc, 32'h114);
    else pass_cnt++;
    clear_inputs();
  endtask

  task automatic test_jump();
    clear_inputs();
    set_pc(32'h2000_0010);
    i_jump = 1; i_imm = 26'h0000040;
    step();
    total_cnt++;
    if (o_pc !== 32'h2000_0100) $display("FAIL jump_pc: got %h want %h", o_pc, 32'h2000_0100);
    else pass_cnt++;
    clear_inputs();
    set_pc(32'h2000_0010);
    i_jump = 1; i_imm = 26'h0000040; i_jr = 1; i_Rs = 32'h400;
    step();
    total_cnt++;
    if (o_pc !== 32'h400) $display("FAIL jr_over_jump_pc: got %h want %h", o_pc, 32'h400);
    else pass_cnt++;
    clear_inputs();
  endtask

  task automatic test_addr_err();
    clear_inputs();
    set_pc(32'h40);
    i_jr = 1; i_Rs = 32'h1002;
    #1;
    total_cnt++;
    if (o_addr_err !== 1'b1) $display("FAIL addr_err_flag: got %b want 1", o_addr_err);
    else pass_cnt++;
    total_cnt++;
    if (o_pcsrc !== 2'b11) $display("FAIL addr_err_pcsrc: got %b want 11", o_pcsrc);
    else pass_cnt++;
    step();
    total_cnt++;
    if (o_pc !== 32'h180) $display("FAIL addr_err_pc: got %h want %h", o_pc, 32'h180);
    else pass_cnt++;
    total_cnt++;
    if (o_epc !== 32'h40) $display("FAIL addr_err_epc: got %h want %h", o_epc, 32'h40);
    else pass_cnt++;
    // Eret masks the misalignment flag and returns to epc.
    i_eret = 1;
    #1;
    total_cnt++;
    if (o_addr_err !== 1'b0) $display("FAIL addr_err_masked: got %b want 0", o_addr_err);
    else pass_cnt++;
    total_cnt++;
    if (o_pcsrc !== 2'b10) $display("FAIL eret_pcsrc: got %b want 10", o_pcsrc);
    else pass_cnt++;
    step();
    total_cnt++;
    if (o_pc !== 32'h40) $display("FAIL eret_pc: got %h want %h", o_pc, 32'h40);
    else pass_cnt++;
    clear_inputs();
  endtask

  task automatic test_stall();
    clear_inputs();
    set_pc(32'h80);
    i_stall = 1; i_jump = 1; i_imm = 26'h0000005;
    #1;
    total_cnt++;
    if (o_pcsrc !== 2'b01) $display("FAIL stall_pcsrc: got %b want 01", o_pcsrc);
    else pass_cnt++;
    step();
    total_cnt++;
    if (o_pc !== 32'h80) $display("FAIL stall_hold_pc: got %h want %h", o_pc, 32'h80);
    else pass_cnt++;
    i_jump = 0; i_exception = 1;
    step();
    total_cnt++;
    if (o_pc !== 32'h180) $display("FAIL stall_exc_pc: got %h want %h", o_pc, 32'h180);
    else pass_cnt++;
    total_cnt++;
    if (o_epc !== 32'h80) $display("FAIL stall_exc_epc: got %h want %h", o_epc, 32'h80);
    else pass_cnt++;
    // eret + exception: eret wins, epc must not be overwritten with 0x180
    i_stall = 0; i_eret = 1; i_exception = 1;
    step();
    total_cnt++;
    if (o_pc !== 32'h80) $display("FAIL eret_exc_pc: got %h want %h", o_pc, 32'h80);
    else pass_cnt++;
    total_cnt++;
    if (o_epc !== 32'h80) $display("FAIL eret_exc_epc: got %h want %h", o_epc, 32'h80);
    else pass_cnt++;
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    set_pc(32'h300);
    i_rst = 1; i_stall = 1; i_exception = 1;
    step();
    i_rst = 0;
    clear_inputs();
    total_cnt++;
    if (o_pc !== 32'h0) $display("FAIL rst_mid_pc: got %h want %h", o_pc, 32'h0);
    else pass_cnt++;
    total_cnt++;
    if (o_epc !== 32'h0) $display("FAIL rst_mid_epc: got %h want %h", o_epc, 32'h0);
    else pass_cnt++;
  endtask

`ifdef PC_TRACE_EN
  task automatic test_trace();
    logic [31:0] exp_q[$];
    clear_inputs();
    i_rst = 1; step(); i_rst = 0;
    for (int k = 1; k <= 10; k++) begin
      exp_q.push_back(32'(k - 1) * 32'h100);
      set_pc(32'(k) * 32'h100);
    end
    total_cnt++;
    if (o_trace_cnt !== 4'd8) $display("FAIL trace_cnt: got %0d want 8", o_trace_cnt);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      i_trace_idx = 3'(i);
      #1;
      total_cnt++;
      if (o_trace_pc !== exp_q[9 - i])
        $display("FAIL trace_idx%0d: got %h want %h", i, o_trace_pc, exp_q[9 - i]);
      else pass_cnt++;
    end
    // A stalled jump is not a redirect and must not be recorded.
    i_trace_idx = '0; i_stall = 1; i_jump = 1;
    step();
    clear_inputs();
    total_cnt++;
    if (o_trace_pc !== 32'h900) $display("FAIL trace_stall_idx0: got %h want %h", o_trace_pc, 32'h900);
    else pass_cnt++;
    i_rst = 1; step(); i_rst = 0;
    total_cnt++;
    if (o_trace_cnt !== 4'd0) $display("FAIL trace_rst_cnt: got %0d want 0", o_trace_cnt);
    else pass_cnt++;
    total_cnt++;
    if (o_trace_pc !== 32'h0) $display("FAIL trace_rst_rd: got %h want %h", o_trace_pc, 32'h0);
    else pass_cnt++;
    total_cnt++;
    if (o_pc !== 32'h0) $display("FAIL trace_rst_pc: got %h want %h", o_pc, 32'h0);
    else pass_cnt++;
  endtask
`else
  task automatic test_trace();
    clear_inputs();
    set_pc(32'h500);
    i_trace_idx = 3'd0;
    #1;
    total_cnt++;
    if (o_trace_cnt !== 4'd0) $display("FAIL trace_off_cnt: got %0d want 0", o_trace_cnt);
    else pass_cnt++;
    total_cnt++;
    if (o_trace_pc !== 32'h0) $display("FAIL trace_off_pc: got %h want %h", o_trace_pc, 32'h0);
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_branch();
    test_jump();
    test_addr_err();
    test_stall();
    test_reset_mid();
    test_trace();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised successor to the combinational next-PC logic, and owner of the architectural PC register.
- Each cycle it selects the next PC from sequential, branch, jump, jump-register, exception-vector or exception-return sources.
- Captures EPC on exceptions and flags misaligned jump-register targets.
- Sits at the front of the unpipelined core, feeding instruction memory; decode/ALU drive the control inputs.

Parameters:
ADDR_W, 32, PC/address width; legal range 29..64 (jump splice needs ADDR_W-28 upper bits).
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
EXC_VECTOR, 32'h0000_0180, PC loaded on exception.
TRACE_DEPTH, 8, entries in redirect trace buffer (power of two, 2..64; used only with PC_TRACE_EN).

Ports:
i_clk  in  1  clock; all state updates on rising edge.
i_rst  in  1  synchronous active-high reset.
i_stall  in  1  hold PC (memory/multicycle wait).
i_imm  in  26  instruction immediate field (branch uses [15:0]).
i_jump  in  1  J/JAL.
i_beq  in  1  BEQ decoded.
i_bne  in  1  BNE decoded.
i_zerof  in  1  ALU zero flag.
i_jr  in  1  JR/JALR.
i_Rs  in  ADDR_W  register-file Rs value.
i_eret  in  1  exception return.
i_exception  in  1  exception request.
o_pc  out  ADDR_W  current PC (registered).
o_pc_plus4  out  ADDR_W  o_pc+4 (combinational, wraps modulo 2^ADDR_W).
o_epc  out  ADDR_W  exception PC register.
o_pcsrc  out  2  00 seq, 01 branch/jump/jr, 10 eret, 11 exception.
o_addr_err  out  1  JR target misaligned this cycle (combinational).
i_trace_idx  in  log2(TRACE_DEPTH)  trace read index; 0 = newest (PC_TRACE_EN only).
o_trace_pc  out  ADDR_W  trace entry at i_trace_idx (PC_TRACE_EN only).
o_trace_cnt  out  log2(TRACE_DEPTH)+1  valid trace entries, saturating (PC_TRACE_EN only).

Behaviour:
- Reset (sync, wins over everything):
  - o_pc=RESET_VECTOR, o_epc=0.
  - Trace buffer cleared: write pointer=0, o_trace_cnt=0.
  - Reset asserted mid-stall or mid-exception discards the pending event.
- Targets:
  - branch = o_pc_plus4 + (sext(i_imm[15:0])<<2).
  - jump = {o_pc_plus4[ADDR_W-1:28], i_imm, 2'b00}.
  - jr = i_Rs.
  - All arithmetic is modulo 2^ADDR_W.
- o_addr_err = i_jr & (i_Rs[1:0]!=0) & ~i_eret & ~i_exception.
- Priority (highest first), applied on the next clock edge:
  1. i_eret: pc<=o_epc; o_pcsrc=10.
  2. i_exception or o_addr_err: pc<=EXC_VECTOR; epc<=o_pc; o_pcsrc=11.
  3. i_jr (aligned): pc<=i_Rs; o_pcsrc=01.
  4. i_jump: pc<=jump; o_pcsrc=01.
  5. taken branch, (i_beq&i_zerof)|(i_bne&~i_zerof): pc<=branch; o_pcsrc=01.
  6. otherwise: pc<=o_pc_plus4; o_pcsrc=00.
  - i_jr and i_jump together: jr wins.
  - i_beq and i_bne together: taken if either condition holds.
- o_pcsrc is combinational from the current inputs and reflects the selected source even while stalled.
- Stall:
  - i_stall=1 holds pc and ignores rows 3-6.
  - eret and exception (rows 1-2) override stall and update the same cycle.
  - epc is written only by row 2.
- Eret and exception in the same cycle: eret taken, exception dropped, epc unchanged.
- Latency: one cycle from input to new o_pc; o_pc_plus4 and o_addr_err are zero-latency.

Optional Feature:
PC_TRACE_EN
- Defined:
  - Every non-sequential PC update (rows 1-5, not stalled-away) writes the pre-update o_pc into a circular buffer of TRACE_DEPTH entries.
  - Write pointer wraps; the oldest entry is overwritten when full.
  - o_trace_cnt saturates at TRACE_DEPTH.
  - Read is combinational; an index >= o_trace_cnt returns 0.
  - A write and a read in the same cycle return pre-write contents.
- Undefined: trace ports are tied to 0 and no trace storage is generated.

Decomposition:
- Shared package pc_pkg:
  - pcsrc encoding constants PCSRC_SEQ/BR/ERET/EXC.
  - Default RESET_VECTOR and EXC_VECTOR constants.
  - Instruction-field widths IMM26_W/IMM16_W.
- One natural sub-module, pc_trace_buf: the circular trace buffer, instantiated only under PC_TRACE_EN.
- Target calculation and priority select stay inline.

Test Plan:
- Reset then 3 free cycles -> o_pc 0,4,8,12; o_pcsrc=00; o_epc=0.
- pc=0x100, i_beq=1, i_zerof=1, imm16=0xFFFE -> next pc=0x0FC; same inputs with i_zerof=0 -> next pc=0x104.
- pc=0x2000_0010, i_jump=1, imm=0x0000040 -> next pc=0x2000_0100; i_jr=1, i_Rs=0x400 same cycle -> pc=0x400.
- pc=0x40, i_jr=1, i_Rs=0x1002 -> o_addr_err=1, next pc=0x180, o_epc=0x40, o_pcsrc=11; then i_eret=1 -> pc=0x40.
- i_stall=1 with i_jump=1 -> pc held; i_stall=1 with i_exception=1 at pc=0x80 -> pc=0x180, epc=0x80; i_eret+i_exception together -> pc=epc, epc unchanged.
- PC_TRACE_EN, TRACE_DEPTH=8: 10 taken jumps -> o_trace_cnt=8, idx0 = last source PC, idx7 = third source PC; i_rst mid-sequence -> cnt=0, pc=RESET_VECTOR.
